regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised successor to the CPU register file.
//  - Configurable width, depth and read-port count.
//  - Optional write-to-read bypass and hardwired-zero register 0.
//  - Hardware clear sequencer zeroes every entry after reset or on request.
//  - Sits in the ID stage of the MIPS32 pipeline: reads feed ID/EX, the write port is driven from WB.
// PARAMETERS
//  DATA_W    32  bits per register
//  ADDR_W    5   address bits; DEPTH = 2**ADDR_W entries
//  NUM_RD    2   number of independent read ports (1..4)
//  BYPASS    1   1: same-cycle write data forwarded to matching read ports
//  ZERO_REG  1   1: entry 0 always reads 0, writes to it are discarded
// PORTS
//  clk      in   1              rising-edge clock
//  rst      in   1              synchronous, active-high reset
//  we       in   1              write enable
//  wa       in   ADDR_W         write address
//  wd       in   DATA_W         write data
//  ra       in   NUM_RD*ADDR_W  packed read addresses; port i = ra[i*ADDR_W +: ADDR_W]
//  rd       out  NUM_RD*DATA_W  packed read data; port i = rd[i*DATA_W +: DATA_W]
//  clr_req  in   1              pulse: start a full clear (sampled only when idle)
//  busy     out  1              1 while the clear sequencer runs; all writes are ignored
// BEHAVIOUR
//  FSM states: IDLE, CLEAR. State and clr_ptr (ADDR_W bits) are registered.
//  Reset:
//   - rst=1 at an edge sets state=CLEAR and clr_ptr=0; busy=1 from the following cycle.
//   - rst takes priority over clr_req and we.
//   - rst during CLEAR restarts the clear at clr_ptr=0.
//  CLEAR:
//   - Each edge writes 0 to entry clr_ptr and increments clr_ptr.
//   - At the edge where clr_ptr==DEPTH-1, the last entry is cleared and state goes to IDLE.
//   - busy is high for exactly DEPTH cycles.
//   - we/wa/wd are ignored; the write is dropped and not queued.
//   - clr_req is ignored.
//   - All rd ports return 0, with no bypass.
//  IDLE:
//   - clr_req=1 at an edge enters CLEAR with clr_ptr=0; a write in that same cycle is performed first.
//   - busy is 0.
//  Write: at the edge, if we && state==IDLE && !(ZERO_REG && wa==0), then mem[wa] <= wd.
//  Read: combinational, zero latency.
//   - Base value: rd_i = mem[ra_i].
//   - If ZERO_REG and ra_i==0, rd_i = 0.
//   - Else if BYPASS and we and state==IDLE and wa==ra_i, rd_i = wd (new data is visible in the write cycle).
//   - BYPASS=0: new data is visible from the cycle after the write edge.
//  Ports are independent; any number may address the same entry.
//  No output registers: rd tracks ra/mem. busy is registered (reset value 1 after rst, 0 in IDLE).
//  ADDR_W widths are exact; no address wraps or truncation beyond DEPTH-1.
// TESTING
//  1 Reset: rst=1 for 1 cycle.
//    -> busy=1 for 32 cycles, then 0.
//    -> All 32 entries read 0x00000000 on every port.
//  2 Write then read: we=1, wa=5, wd=0xDEADBEEF, then ra0=5, ra1=5.
//    -> BYPASS=1: both ports show 0xDEADBEEF in the write cycle and afterwards.
//    -> BYPASS=0: the write-cycle read shows the old value 0.
//  3 Zero register: we=1, wa=0, wd=0xFFFFFFFF; ra0=0.
//    -> rd0=0 in the write cycle and after.
//    -> With ZERO_REG=0: rd0=0xFFFFFFFF after the edge.
//  4 Clear request: fill r1..r31 with r<<4, then pulse clr_req.
//    -> busy=1 for 32 cycles; we=1 wa=7 wd=0x1234 during busy is dropped.
//    -> Afterwards all entries read 0.
//  5 Reset mid-clear: rst at clr_ptr=10.
//    -> Clear restarts; busy stays high for 32 more cycles.
//    -> Simultaneous rst+clr_req+we behaves as plain reset.
//  6 NUM_RD=3, DATA_W=16: write r3=0xA5A5, r4=0x5A5A; ra={3,4,3}.
//    -> rd={0xA5A5,0x5A5A,0xA5A5}, unpacked at the correct bit slices.

Source files
------------

// File: rtl/regfile_multiport.sv
// ============================================================================
//  Module      : regfile_multiport
//  Description : Parametrised multi-read-port register file with optional
//                write-to-read bypass, hardwired-zero entry 0 and a hardware
//                clear sequencer that zeroes every entry after reset/request.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     clr_req,
    output logic                     busy
);

    localparam int C_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(C_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              r_state_q;
    state_t              w_state_d;
    logic [ADDR_W-1:0]   r_clr_ptr_q;
    logic [ADDR_W-1:0]   w_clr_ptr_d;
    logic [DATA_W-1:0]   r_mem_q [C_DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_wa;
    logic [DATA_W-1:0]   w_mem_wd;
    logic                w_user_we;

    always_comb begin
        w_state_d   = r_state_q;
        w_clr_ptr_d = r_clr_ptr_q;
        w_mem_we    = 1'b0;
        w_mem_wa    = wa;
        w_mem_wd    = wd;
        w_user_we   = we && (r_state_q == ST_IDLE);

        if (rst) begin
            w_state_d   = ST_CLEAR;
            w_clr_ptr_d = '0;
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    // A write in the same cycle as clr_req lands before the clear begins.
                    w_mem_we = we && !((ZERO_REG != 0) && (wa == '0));
                    if (clr_req) begin
                        w_state_d   = ST_CLEAR;
                        w_clr_ptr_d = '0;
                    end
                end
                ST_CLEAR: begin
                    w_mem_we    = 1'b1;
                    w_mem_wa    = r_clr_ptr_q;
                    w_mem_wd    = '0;
                    w_clr_ptr_d = r_clr_ptr_q + 1'b1;
                    if (r_clr_ptr_q == C_LAST_PTR) begin
                        w_state_d = ST_IDLE;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_CLEAR;
            r_clr_ptr_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_clr_ptr_q <= w_clr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem_q[w_mem_wa] <= w_mem_wd;
        end
    end

    assign busy = (r_state_q == ST_CLEAR);

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = ra[gi*ADDR_W +: ADDR_W];

        always_comb begin
            w_rd = r_mem_q[w_ra];
            if (r_state_q != ST_IDLE) begin
                w_rd = '0;
            end else if ((ZERO_REG != 0) && (w_ra == '0)) begin
                w_rd = '0;
            end else if ((BYPASS != 0) && w_user_we && (w_ra == wa)) begin
                w_rd = wd;
            end
        end

        assign rd[gi*DATA_W +: DATA_W] = w_rd;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
//  Module      : tb_regfile_multiport
//  Description : Self-checking bench for regfile_multiport; two instances
//                (default config and a 16-bit/3-port/no-bypass/no-zero one).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

    localparam int C_DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        clr_req;
    logic [9:0]  ra_a;
    logic [63:0] rd_a;
    logic        busy_a;
    logic [14:0] ra_b;
    logic [47:0] rd_b;
    logic        busy_b;

    always #5 clk = ~clk;

    regfile_multiport #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
        .ra(ra_a), .rd(rd_a), .clr_req(clr_req), .busy(busy_a)
    );

    regfile_multiport #(
        .DATA_W(16), .ADDR_W(5), .NUM_RD(3), .BYPASS(0), .ZERO_REG(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd[15:0]),
        .ra(ra_b), .rd(rd_b), .clr_req(clr_req), .busy(busy_b)
    );

    // Reference model: register contents and remaining busy cycles.
    logic [31:0] mem_a [C_DEPTH];
    logic [15:0] mem_b [C_DEPTH];
    int          busy_left;
    bit          chk_en;
    int          tests;
    int          fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < C_DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endtask

    // Check the current cycle, advance one clock edge, update the model.
    task automatic cycle();
        logic [4:0]  a;
        logic [31:0] exp_a;
        logic [15:0] exp_b;
        #1;
        if (chk_en) begin
            check("busy_a", 64'(busy_a), 64'(busy_left > 0));
            check("busy_b", 64'(busy_b), 64'(busy_left > 0));
            for (int i = 0; i < 2; i++) begin
                a = ra_a[i*5 +: 5];
                if (busy_left > 0)          exp_a = '0;
                else if (a == 5'd0)         exp_a = '0;
                else if (we && (wa == a))   exp_a = wd;
                else                        exp_a = mem_a[a];
                check($sformatf("rd_a[%0d] ra=%0d", i, a), 64'(rd_a[i*32 +: 32]), 64'(exp_a));
            end
            for (int i = 0; i < 3; i++) begin
                a = ra_b[i*5 +: 5];
                exp_b = (busy_left > 0) ? 16'h0 : mem_b[a];
                check($sformatf("rd_b[%0d] ra=%0d", i, a), 64'(rd_b[i*16 +: 16]), 64'(exp_b));
            end
        end
        @(posedge clk);
        if (rst) begin
            busy_left = C_DEPTH;
            model_clear();
        end else if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (we && (wa != 5'd0)) mem_a[wa] = wd;
            if (we)                 mem_b[wa] = wd[15:0];
            if (clr_req) begin
                busy_left = C_DEPTH;
                model_clear();
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we = 1'b0; clr_req = 1'b0; wa = '0; wd = '0;
    endtask

    task automatic sweep_reads();
        for (int r = 0; r < C_DEPTH; r++) begin
            ra_a = {5'(r), 5'(C_DEPTH - 1 - r)};
            ra_b = {5'(r), 5'(r + 7), 5'(C_DEPTH - 1 - r)};
            cycle();
        end
    endtask

    initial begin
        tests = 0; fails = 0; chk_en = 1'b0; busy_left = 0;
        idle_inputs();
        ra_a = '0; ra_b = '0;
        @(negedge clk);

        // Reset: 32 busy cycles, then everything reads zero.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_en = 1'b1;
        for (int c = 0; c < C_DEPTH + 2; c++) begin
            ra_a = 10'($urandom); ra_b = 15'($urandom);
            cycle();
        end
        sweep_reads();

        // Write then read, with bypass on port A visible in the write cycle.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra_a = {5'd5, 5'd5}; ra_b = {5'd5, 5'd5, 5'd5};
        cycle();
        idle_inputs();
        cycle();

        // Zero register: discarded on A, stored on B.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra_a = {5'd0, 5'd0}; ra_b = {5'd0, 5'd0, 5'd0};
        cycle();
        idle_inputs();
        cycle();

        // Fill r1..r31, clear request, write attempts while busy.
        for (int r = 1; r < C_DEPTH; r++) begin
            we = 1'b1; wa = 5'(r); wd = 32'(r << 4); ra_a = {5'(r), 5'(r - 1)}; ra_b = {5'(r), 5'(r - 1), 5'd0};
            cycle();
        end
        idle_inputs();
        sweep_reads();
        clr_req = 1'b1;
        cycle();
        clr_req = 1'b0;
        for (int c = 0; c < C_DEPTH; c++) begin
            we = 1'b1; wa = 5'd7; wd = 32'h1234; ra_a = {5'd7, 5'(c)}; ra_b = {5'd7, 5'(c), 5'd7};
            cycle();
        end
        idle_inputs();
        sweep_reads();

        // Reset while clear pointer is at 10 restarts the full clear.
        we = 1'b1; wa = 5'd9; wd = 32'h0BADF00D; ra_a = {5'd9, 5'd9};
        cycle();
        clr_req = 1'b1; we = 1'b0;
        cycle();
        clr_req = 1'b0;
        repeat (10) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (C_DEPTH + 2) cycle();

        // rst + clr_req + we together behaves as plain reset.
        rst = 1'b1; clr_req = 1'b1; we = 1'b1; wa = 5'd12; wd = 32'h55AA55AA; ra_a = {5'd12, 5'd3};
        cycle();
        idle_inputs();
        repeat (C_DEPTH + 1) cycle();
        ra_a = {5'd12, 5'd12}; ra_b = {5'd12, 5'd12, 5'd12};
        cycle();

        // Three-port 16-bit slicing.
        we = 1'b1; wa = 5'd3; wd = 32'h0000A5A5; cycle();
        we = 1'b1; wa = 5'd4; wd = 32'h00005A5A; cycle();
        idle_inputs();
        ra_b = {5'd3, 5'd4, 5'd3}; ra_a = {5'd4, 5'd3};
        cycle();

        // Randomised traffic with occasional clear requests and resets.
        for (int c = 0; c < 800; c++) begin
            rst     = ($urandom_range(0, 249) == 0);
            clr_req = ($urandom_range(0, 79) == 0);
            we      = 1'($urandom_range(0, 1));
            wa      = 5'($urandom);
            wd      = $urandom;
            ra_a    = 10'($urandom);
            ra_b    = 15'($urandom);
            if ($urandom_range(0, 2) == 0) ra_a[4:0] = wa;
            if ($urandom_range(0, 2) == 0) ra_b[9:5] = wa;
            cycle();
        end
        idle_inputs();
        repeat (C_DEPTH + 1) cycle();
        sweep_reads();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
